// File: rtl/sparc_pkg.sv
// Shared SPARC integer-unit definitions: Bicc condition encodings, icc bit
// positions and the branch sequencer state type.
package sparc_pkg;

  localparam logic [3:0] COND_BN   = 4'h0;
  localparam logic [3:0] COND_BE   = 4'h1;
  localparam logic [3:0] COND_BLE  = 4'h2;
  localparam logic [3:0] COND_BL   = 4'h3;
  localparam logic [3:0] COND_BLEU = 4'h4;
  localparam logic [3:0] COND_BCS  = 4'h5;
  localparam logic [3:0] COND_BNEG = 4'h6;
  localparam logic [3:0] COND_BVS  = 4'h7;
  localparam logic [3:0] COND_BA   = 4'h8;
  localparam logic [3:0] COND_BNE  = 4'h9;
  localparam logic [3:0] COND_BG   = 4'hA;
  localparam logic [3:0] COND_BGE  = 4'hB;
  localparam logic [3:0] COND_BGU  = 4'hC;
  localparam logic [3:0] COND_BCC  = 4'hD;
  localparam logic [3:0] COND_BPOS = 4'hE;
  localparam logic [3:0] COND_BVC  = 4'hF;

  localparam int ICC_N = 3;
  localparam int ICC_Z = 2;
  localparam int ICC_V = 1;
  localparam int ICC_C = 0;

  typedef enum logic {RUN, ANNUL} seq_state_t;

endpackage

// File: rtl/bicc_cond_eval.sv
// Combinational Bicc condition evaluator: t is the taken decision for cond
// against the current {N,Z,V,C}.
module bicc_cond_eval
  import sparc_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] icc,
  output logic       t
);

  logic base;

  // Upper half of the encoding is the complement of the lower half (BN/BA included).
  always_comb begin
    base = 1'b0;
    case (cond[2:0])
      3'd0: base = 1'b0;
      3'd1: base = icc[ICC_Z];
      3'd2: base = icc[ICC_Z] | (icc[ICC_N] ^ icc[ICC_V]);
      3'd3: base = icc[ICC_N] ^ icc[ICC_V];
      3'd4: base = icc[ICC_C] | icc[ICC_Z];
      3'd5: base = icc[ICC_C];
      3'd6: base = icc[ICC_N];
      3'd7: base = icc[ICC_V];
      default: base = 1'b0;
    endcase
    t = cond[3] ? ~base : base;
  end

endmodule

// File: rtl/branch_sequencer.sv
// PC/nPC sequencer with icc register and delayed-branch handling; annulled
// delay slots are tracked by a RUN/ANNUL state machine.
module branch_sequencer
  import sparc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adv,
  input  logic        icc_we,
  input  logic        n_in,
  input  logic        z_in,
  input  logic        v_in,
  input  logic        c_in,
  input  logic        is_bicc,
  input  logic [3:0]  cond,
  input  logic        annul,
  input  logic [21:0] disp22,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic [3:0]  icc,
  output logic        squash,
  output logic        taken
);

  seq_state_t         state, state_nxt;
  logic [31:0]        pc_nxt, npc_nxt;
  logic [3:0]         icc_nxt;
  logic               taken_nxt;
  logic               t;
  logic signed [31:0] disp_ext;

  bicc_cond_eval u_cond_eval (
    .cond (cond),
    .icc  (icc),
    .t    (t)
  );

  assign disp_ext = {{8{disp22[21]}}, disp22, 2'b00};
  assign squash   = (state == ANNUL);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    npc_nxt   = npc;
    icc_nxt   = icc;
    taken_nxt = taken;
    if (adv) begin
      pc_nxt    = npc;
      npc_nxt   = npc + 32'd4;
      taken_nxt = 1'b0;
      state_nxt = RUN;
      // A squashed instruction neither writes icc nor branches.
      if (state == RUN) begin
        if (is_bicc) begin
          if (t)
            npc_nxt = pc + $unsigned(disp_ext);
          taken_nxt = t;
          if (annul && (!t || cond == COND_BA))
            state_nxt = ANNUL;
        end else if (icc_we) begin
          icc_nxt = {n_in, z_in, v_in, c_in};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      pc    <= RESET_PC;
      npc   <= RESET_PC + 32'd4;
      icc   <= 4'b0000;
      taken <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      npc   <= npc_nxt;
      icc   <= icc_nxt;
      taken <= taken_nxt;
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Table-driven bench for branch_sequencer: each vector's expected outputs go
// through a scoreboard queue and are compared one cycle after the advance.
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        adv = 1'b0, icc_we = 1'b0;
  logic        n_in = 1'b0, z_in = 1'b0, v_in = 1'b0, c_in = 1'b0;
  logic        is_bicc = 1'b0, annul = 1'b0;
  logic [3:0]  cond = 4'h0;
  logic [21:0] disp22 = 22'h0;
  logic [31:0] pc, npc;
  logic [3:0]  icc;
  logic        squash, taken;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [3:0]  icc;
    logic        sq;
    logic        tk;
  } out_t;

  typedef struct {
    logic        adv;
    logic        we;
    logic [3:0]  f;
    logic        br;
    logic [3:0]  cond;
    logic        a;
    logic [21:0] d;
    out_t        exp;
  } vec_t;

  vec_t tbl[$];
  out_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  branch_sequencer #(.RESET_PC(32'h0000_0100)) dut (
    .clk     (clk),
    .reset   (reset),
    .adv     (adv),
    .icc_we  (icc_we),
    .n_in    (n_in),
    .z_in    (z_in),
    .v_in    (v_in),
    .c_in    (c_in),
    .is_bicc (is_bicc),
    .cond    (cond),
    .annul   (annul),
    .disp22  (disp22),
    .pc      (pc),
    .npc     (npc),
    .icc     (icc),
    .squash  (squash),
    .taken   (taken)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic a_v, logic we, logic [3:0] f, logic br,
                              logic [3:0] c, logic an, logic [21:0] d,
                              logic [31:0] epc, logic [31:0] enpc,
                              logic [3:0] eicc, logic esq, logic etk);
    vec_t v;
    v.adv = a_v; v.we = we; v.f = f; v.br = br; v.cond = c; v.a = an; v.d = d;
    v.exp = '{pc: epc, npc: enpc, icc: eicc, sq: esq, tk: etk};
    return v;
  endfunction

  task automatic check_out(input string name, input out_t exp);
    out_t got;
    got = '{pc: pc, npc: npc, icc: icc, sq: squash, tk: taken};
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got pc=%h npc=%h icc=%h sq=%b tk=%b, want pc=%h npc=%h icc=%h sq=%b tk=%b",
               name, got.pc, got.npc, got.icc, got.sq, got.tk,
               exp.pc, exp.npc, exp.icc, exp.sq, exp.tk);
    else
      n_pass++;
  endtask

  // Drive one vector just after an edge, retire it on the next edge, then compare.
  task automatic apply(input vec_t v, input string name);
    adv = v.adv; icc_we = v.we;
    {n_in, z_in, v_in, c_in} = v.f;
    is_bicc = v.br; cond = v.cond; annul = v.a; disp22 = v.d;
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      check_out(name, sb.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //             adv we  f     br  cond a  disp22     pc            npc           icc   sq  tk
    tbl.push_back(mk(1, 0, 4'h0, 0, 4'h0, 0, 22'h0,     32'h104,      32'h108,      4'h0, 0, 0));
    tbl.push_back(mk(1, 0, 4'h0, 0, 4'h0, 0, 22'h0,     32'h108,      32'h10C,      4'h0, 0, 0));
    tbl.push_back(mk(1, 0, 4'h0, 0, 4'h0, 0, 22'h0,     32'h10C,      32'h110,      4'h0, 0, 0));
    tbl.push_back(mk(0, 1, 4'hF, 1, 4'h8, 1, 22'h5,     32'h10C,      32'h110,      4'h0, 0, 0));
    tbl.push_back(mk(1, 0, 4'h0, 1, 4'h8, 0, 22'h3D,    32'h110,      32'h200,      4'h0, 0, 1));
    tbl.push_back(mk(1, 1, 4'h8, 0, 4'h0, 0, 22'h0,     32'h200,      32'h204,      4'h8, 0, 0));
    tbl.push_back(mk(1, 0, 4'h0, 1, 4'h3, 0, 22'h4,     32'h204,      32'h210,      4'h8, 0, 1));
    tbl.push_back(mk(1, 0, 4'h0, 0, 4'h0, 0, 22'h0,     32'h210,      32'h214,      4'h8, 0, 0));
    tbl.push_back(mk(1, 0, 4'h0, 1, 4'h8, 0, 22'h3C,    32'h214,      32'h300,      4'h8, 0, 1));
    tbl.push_back(mk(1, 1, 4'h1, 0, 4'h0, 0, 22'h0,     32'h300,      32'h304,      4'h1, 0, 0));
    tbl.push_back(mk(1, 0, 4'h0, 1, 4'h1, 1, 22'h8,     32'h304,      32'h308,      4'h1, 1, 0));
    tbl.push_back(mk(1, 1, 4'hF, 0, 4'h0, 0, 22'h0,     32'h308,      32'h30C,      4'h1, 0, 0));
    tbl.push_back(mk(1, 0, 4'h0, 1, 4'h8, 0, 22'h3E,    32'h30C,      32'h400,      4'h1, 0, 1));
    tbl.push_back(mk(1, 0, 4'h0, 0, 4'h0, 0, 22'h0,     32'h400,      32'h404,      4'h1, 0, 0));
    tbl.push_back(mk(1, 0, 4'h0, 1, 4'h8, 1, 22'h3FFFFF,32'h404,      32'h3FC,      4'h1, 1, 1));
    tbl.push_back(mk(1, 0, 4'h0, 0, 4'h0, 0, 22'h0,     32'h3FC,      32'h400,      4'h1, 0, 0));
    tbl.push_back(mk(1, 0, 4'h0, 1, 4'h8, 0, 22'h41,    32'h400,      32'h500,      4'h1, 0, 1));
    tbl.push_back(mk(1, 1, 4'h4, 0, 4'h0, 0, 22'h0,     32'h500,      32'h504,      4'h4, 0, 0));
    tbl.push_back(mk(1, 0, 4'h0, 1, 4'h1, 0, 22'h40,    32'h504,      32'h600,      4'h4, 0, 1));
    tbl.push_back(mk(1, 0, 4'h0, 1, 4'h8, 0, 22'h7F,    32'h600,      32'h700,      4'h4, 0, 1));
    tbl.push_back(mk(1, 0, 4'h0, 0, 4'h0, 0, 22'h0,     32'h700,      32'h704,      4'h4, 0, 0));
    tbl.push_back(mk(1, 1, 4'h0, 1, 4'h9, 0, 22'h10,    32'h704,      32'h708,      4'h4, 0, 0));
    tbl.push_back(mk(1, 0, 4'h0, 1, 4'hC, 1, 22'h5,     32'h708,      32'h70C,      4'h4, 1, 0));
    tbl.push_back(mk(1, 0, 4'h0, 1, 4'h8, 1, 22'h100,   32'h70C,      32'h710,      4'h4, 0, 0));
    tbl.push_back(mk(1, 0, 4'h0, 1, 4'h4, 1, 22'h8,     32'h710,      32'h72C,      4'h4, 0, 1));
    tbl.push_back(mk(1, 0, 4'h0, 0, 4'h0, 0, 22'h0,     32'h72C,      32'h730,      4'h4, 0, 0));
    tbl.push_back(mk(1, 0, 4'h0, 1, 4'h0, 1, 22'h20,    32'h730,      32'h734,      4'h4, 1, 0));

    // Reset values while reset is held.
    #12;
    check_out("reset_hold", '{pc: 32'h100, npc: 32'h104, icc: 4'h0, sq: 1'b0, tk: 1'b0});
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset while the delay slot is annulled.
    adv = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_out("async_reset", '{pc: 32'h100, npc: 32'h104, icc: 4'h0, sq: 1'b0, tk: 1'b0});
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_out("reset_release_hold", '{pc: 32'h100, npc: 32'h104, icc: 4'h0, sq: 1'b0, tk: 1'b0});

    // Branch to the top of the address space, then wrap through zero.
    apply(mk(1, 0, 4'h0, 1, 4'h8, 0, 22'h3FFFBE, 32'h104, 32'hFFFF_FFF8, 4'h0, 0, 1), "to_top");
    apply(mk(1, 0, 4'h0, 0, 4'h0, 0, 22'h0,      32'hFFFF_FFF8, 32'hFFFF_FFFC, 4'h0, 0, 0), "top_slot");
    apply(mk(1, 0, 4'h0, 1, 4'h8, 0, 22'h4,      32'hFFFF_FFFC, 32'h8, 4'h0, 0, 1), "wrap_ba");
    apply(mk(1, 0, 4'h0, 0, 4'h0, 0, 22'h0,      32'h8,         32'hC, 4'h0, 0, 0), "wrap_slot");

    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
